aes128_enc_stream: RTL and testbench
====================================

# aes128_enc_stream

Parametrised, iterative AES-128 encryption core with a word-serial streaming interface. It accepts one 128-bit plaintext block and its 128-bit key as 128/DATA_WIDTH beats. It computes one round per cycle with an on-the-fly key schedule, then returns the ciphertext as the same number of beats. It generalises AES128_core: the I/O width is configurable, both sides have ready/valid backpressure, and an optional key-reuse mode is available. It sits between the message-packing front end (MP) and the output formatter.

## Interface
Parameters:
- DATA_WIDTH, 32, I/O word width; legal values 8, 16, 32, 64, 128 (any other value is an elaboration $error).
- NWORDS, 128/DATA_WIDTH (derived, localparam), beats per block.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- MP_dv_in  input  1  input beat valid.
- plaintext_in  input  DATA_WIDTH  plaintext word; first beat is bits 127:(128-DATA_WIDTH).
- key_in  input  DATA_WIDTH  key word, same beat ordering as plaintext_in.
- key_new_in  input  1  load a new key for this block (used only with AES_KEY_REUSE_EN).
- in_ready_out  output  1  core can accept an input beat.
- data_out  output  DATA_WIDTH  ciphertext word, MSW first.
- core_dv_out  output  1  data_out valid.
- out_ready_in  input  1  downstream accepts the current output word.

## Operation
- States:
  - IDLE/LOAD
  - INIT (initial AddRoundKey)
  - ROUND (rounds 1..10)
  - OUT
- Beat transfer: a beat is accepted on a rising edge where MP_dv_in && in_ready_out. in_ready_out is 1 only in IDLE/LOAD.
- Load:
  - A beat counter (0..NWORDS-1) shifts each accepted word into the 128-bit state and key registers, big-endian.
  - Gaps (MP_dv_in low) hold the counter and registers.
  - Accepting beat NWORDS-1 moves to INIT.
- INIT: state ^= key; the working round key is set to the cipher key, rcon is set to 0x01; go to ROUND.
- ROUND:
  - Each cycle applies SubBytes, ShiftRows, MixColumns (omitted in round 10), then AddRoundKey with the next round key.
  - The next round key is computed combinationally from the working key and rcon.
  - rcon advances by xtime: 01,02,04,08,10,20,40,80,1b,36.
  - A round counter runs 1..10; after round 10 go to OUT.
- OUT:
  - core_dv_out is 1 and data_out presents word k of the ciphertext.
  - An edge with out_ready_in high advances k.
  - After word NWORDS-1 is taken, go to IDLE.
- Encryption only; decryption is out of scope.
- All arithmetic is GF(2^8) with polynomial 0x11b; S-box per FIPS-197.

## Timing
- Reset values:
  - in_ready_out = 1, core_dv_out = 0, data_out = 0.
  - State, key, counters and rcon are all 0; FSM is in IDLE.
- Latency: core_dv_out rises 11 cycles after the edge that accepts the last input beat, i.e. INIT (1 cycle) plus 10 rounds.
- Output hold: while core_dv_out && !out_ready_in, data_out is held stable.
- data_out is 0 whenever core_dv_out is 0.
- No overlap between blocks: in_ready_out rises the cycle after the last output word is taken. Throughput is one block per NWORDS + 11 + NWORDS cycles minimum.
- MP_dv_in asserted outside IDLE/LOAD is ignored; no data is captured.
- Reset mid-operation (any state): immediate return to reset values. Any partial block is discarded.
- DATA_WIDTH=128: single-beat load and single-beat output, same 11-cycle latency.

## Configuration
- AES_KEY_REUSE_EN defined:
  - key_new_in is sampled with the first beat of a block.
  - If it is 1, key words are captured and stored in a retained cipher-key register.
  - If it is 0, key_in is ignored for the whole block and the retained key is used.
  - The retained key resets to all zeros.
- AES_KEY_REUSE_EN undefined: key_new_in is unused; key words are captured on every block and no retained-key register exists.

## Structure
- Package aes_pkg holds:
  - sbox function (256-entry)
  - xtime function
  - rcon_next function
  - FSM state enum typedef
  - block width constant (128)
- Sub-module aes_key_step: combinational one-step key expansion (RotWord, SubWord, rcon XOR, word chaining); instantiated once.
- Round datapath is kept inside aes128_enc_stream.

## Test plan
1. DATA_WIDTH=32, gap-free load, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> words 3925841d, 02dc09fb, dc118597, 196a0b32; core_dv_out 11 cycles after the last accept.
2. DATA_WIDTH=8, MP_dv_in with random gaps, key 000102…0f, pt 00112233445566778899aabbccddeeff -> 16 bytes 69 c4 e0 d8 … c5 5a.
3. DATA_WIDTH=32 with out_ready_in pattern 1,0,0,1,0,1,1 -> each word held stable during stalls, no word lost or duplicated; in_ready_out stays 0 until the 4th word is taken.
4. rst_n pulsed low during round 5 -> outputs return to reset values at once; in_ready_out=1 after release; the next block (vector 1) produces a correct result.
5. AES_KEY_REUSE_EN defined: block 1 is vector 1 with key_new_in=1; block 2 is the same pt with key_new_in=0 and key_in=ffff… -> 3925841d02dc09fbdc118597196a0b32.
6. DATA_WIDTH=128: vector 2 in one beat -> 69c4e0d86a7b0430d8cdb78070b4c55a in one beat; MP_dv_in held high during ROUND causes no capture.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 block constant, FSM state type, S-box and GF(2^8) helpers
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {ST_LOAD, ST_INIT, ST_ROUND, ST_OUT} aes_state_t;

  // Entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_next(input logic [7:0] r);
    return xtime(r);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one combinational AES-128 key expansion step
module aes_key_step
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] key,
  input  logic [7:0]         rcon,
  output logic [BLOCK_W-1:0] next_key
);

  logic [31:0] rot;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rot  = {key[23:0], key[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
    n0   = key[127:96] ^ temp;
    n1   = key[95:64] ^ n0;
    n2   = key[63:32] ^ n1;
    n3   = key[31:0] ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_enc_stream.sv
// rtl/aes128_enc_stream.sv - iterative AES-128 encryptor with word-serial ready/valid I/O
// Optional retained cipher key selected by AES_KEY_REUSE_EN.
module aes128_enc_stream
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MP_dv_in,
  input  logic [DATA_WIDTH-1:0] plaintext_in,
  input  logic [DATA_WIDTH-1:0] key_in,
  input  logic                  key_new_in,
  output logic                  in_ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  core_dv_out,
  input  logic                  out_ready_in
);

  localparam int NWORDS = BLOCK_W / DATA_WIDTH;
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NWORDS - 1);
  localparam logic [3:0] LAST_ROUND = 4'd10;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 &&
      DATA_WIDTH != 64 && DATA_WIDTH != 128) begin : g_bad_width
    $error("aes128_enc_stream: DATA_WIDTH must be 8, 16, 32, 64 or 128");
  end

  aes_state_t fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, key_q, cipher_key, next_key, round_out;
  logic [BLOCK_W-1:0] load_state, load_key, shift_out;
  logic [BLOCK_W-1:0] sb_v, sr_v, mc_v;
  logic [7:0] rcon_q, a0, a1, a2, a3;
  logic [3:0] round_q;
  logic [CW-1:0] beat_q;
  logic accept, take;

  // Loading shifts words in at the bottom; output shifts the next word up to the top.
  if (NWORDS == 1) begin : g_one
    assign load_state = plaintext_in;
    assign load_key   = key_in;
    assign shift_out  = '0;
  end else begin : g_many
    assign load_state = {state_q[BLOCK_W-DATA_WIDTH-1:0], plaintext_in};
    assign load_key   = {key_q[BLOCK_W-DATA_WIDTH-1:0], key_in};
    assign shift_out  = {state_q[BLOCK_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
  end

`ifdef AES_KEY_REUSE_EN
  logic [BLOCK_W-1:0] kept_key_q;
  logic key_new_q;
  assign cipher_key = key_new_q ? key_q : kept_key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kept_key_q <= '0;
      key_new_q  <= 1'b0;
    end else begin
      if (accept && beat_q == '0) key_new_q <= key_new_in;
      if (fsm_q == ST_INIT) kept_key_q <= cipher_key;
    end
  end
`else
  logic unused_key_new;
  assign unused_key_new = key_new_in;
  assign cipher_key = key_q;
`endif

  aes_key_step u_key_step (.key(key_q), .rcon(rcon_q), .next_key(next_key));

  always_comb begin
    sb_v = '0;
    sr_v = '0;
    mc_v = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int i = 0; i < 16; i++) sb_v[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr_v[127-8*(4*c+r) -: 8] = sb_v[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr_v[127-32*c -: 8];
      a1 = sr_v[119-32*c -: 8];
      a2 = sr_v[111-32*c -: 8];
      a3 = sr_v[103-32*c -: 8];
      mc_v[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    round_out = ((round_q == LAST_ROUND) ? sr_v : mc_v) ^ next_key;
  end

  always_comb begin
    fsm_d = fsm_q;
    in_ready_out = 1'b0;
    core_dv_out = 1'b0;
    case (fsm_q)
      ST_LOAD: begin
        in_ready_out = 1'b1;
        if (MP_dv_in && beat_q == LAST_BEAT) fsm_d = ST_INIT;
      end
      ST_INIT:  fsm_d = ST_ROUND;
      ST_ROUND: if (round_q == LAST_ROUND) fsm_d = ST_OUT;
      ST_OUT: begin
        core_dv_out = 1'b1;
        if (out_ready_in && beat_q == LAST_BEAT) fsm_d = ST_LOAD;
      end
      default: fsm_d = ST_LOAD;
    endcase
  end

  assign accept   = in_ready_out && MP_dv_in;
  assign take     = core_dv_out && out_ready_in;
  assign data_out = core_dv_out ? state_q[BLOCK_W-1 -: DATA_WIDTH] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_LOAD;
    else        fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      beat_q  <= '0;
    end else begin
      case (fsm_q)
        ST_LOAD: if (accept) begin
          state_q <= load_state;
          key_q   <= load_key;
          beat_q  <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
        ST_INIT: begin
          state_q <= state_q ^ cipher_key;
          key_q   <= cipher_key;
          rcon_q  <= 8'h01;
          round_q <= 4'd1;
        end
        ST_ROUND: begin
          state_q <= round_out;
          key_q   <= next_key;
          rcon_q  <= rcon_next(rcon_q);
          round_q <= round_q + 4'd1;
        end
        ST_OUT: if (take) begin
          state_q <= shift_out;
          beat_q  <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_stream.sv
// tb/tb_aes128_enc_stream.sv - directed bench for aes128_enc_stream at 32-, 8- and 128-bit widths
module tb_aes128_enc_stream;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic dv32, kn32, inr32, cdv32, rdy32;
  logic [31:0] pt32, k32, do32;
  logic dv8, kn8, inr8, cdv8, rdy8;
  logic [7:0] pt8, k8, do8;
  logic dv128, kn128, inr128, cdv128, rdy128;
  logic [127:0] pt128, k128, do128;

  aes128_enc_stream #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .MP_dv_in(dv32), .plaintext_in(pt32), .key_in(k32),
    .key_new_in(kn32), .in_ready_out(inr32), .data_out(do32), .core_dv_out(cdv32),
    .out_ready_in(rdy32));
  aes128_enc_stream #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .MP_dv_in(dv8), .plaintext_in(pt8), .key_in(k8),
    .key_new_in(kn8), .in_ready_out(inr8), .data_out(do8), .core_dv_out(cdv8),
    .out_ready_in(rdy8));
  aes128_enc_stream #(.DATA_WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .MP_dv_in(dv128), .plaintext_in(pt128), .key_in(k128),
    .key_new_in(kn128), .in_ready_out(inr128), .data_out(do128), .core_dv_out(cdv128),
    .out_ready_in(rdy128));

  int total = 0;
  int bad = 0;
  logic [7:0] sb_m [256];
  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];
  logic [127:0] kept_m [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [7:0] rc;
    logic [31:0] tmp;
    logic [127:0] rk, res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_m[tmp[31:24]], sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    rk = {w[0], w[1], w[2], w[3]};
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ rk[127-8*j -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb_m[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = s[4*c+row];
          for (int row = 0; row < 4; row++)
            s[4*c+row] = gmul(a[row], 8'h02) ^ gmul(a[(row+1)%4], 8'h03) ^ a[(row+2)%4] ^ a[(row+3)%4];
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int j = 0; j < 16; j++) s[j] ^= rk[127-8*j -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic int wid(input int inst);
    case (inst)
      0: return 32;
      1: return 8;
      default: return 128;
    endcase
  endfunction

  function automatic logic [127:0] word_of(input logic [127:0] v, input int b, input int w);
    return (v << (b * w)) >> (128 - w);
  endfunction

  function automatic logic get_inr(input int inst);
    case (inst)
      0: return inr32;
      1: return inr8;
      default: return inr128;
    endcase
  endfunction

  function automatic logic get_dv(input int inst);
    case (inst)
      0: return cdv32;
      1: return cdv8;
      default: return cdv128;
    endcase
  endfunction

  function automatic int q_size(input int inst);
    case (inst)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int inst, input logic [127:0] v);
    case (inst)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic drive(input int inst, input logic v, input logic [127:0] pw,
                       input logic [127:0] kw, input logic kn);
    case (inst)
      0: begin dv32 = v; pt32 = pw[31:0]; k32 = kw[31:0]; kn32 = kn; end
      1: begin dv8 = v; pt8 = pw[7:0]; k8 = kw[7:0]; kn8 = kn; end
      default: begin dv128 = v; pt128 = pw; k128 = kw; kn128 = kn; end
    endcase
  endtask

  task automatic set_rdy(input int inst, input logic v);
    case (inst)
      0: rdy32 = v;
      1: rdy8 = v;
      default: rdy128 = v;
    endcase
  endtask

  task automatic mon(input int inst, input logic dv, input logic [127:0] dout, input logic rdy);
    logic [127:0] exp;
    int n;
    n = q_size(inst);
    if (!dv) chk("data_out_idle_zero", dout, 128'h0);
    else begin
      chk("output_word_expected", (n != 0) ? 128'h1 : 128'h0, 128'h1);
      if (n != 0) begin
        case (inst)
          0: begin exp = q0[0]; if (rdy) void'(q0.pop_front()); end
          1: begin exp = q1[0]; if (rdy) void'(q1.pop_front()); end
          default: begin exp = q2[0]; if (rdy) void'(q2.pop_front()); end
        endcase
        chk("cipher_word", dout, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, cdv32, 128'(do32), rdy32);
    mon(1, cdv8, 128'(do8), rdy8);
    mon(2, cdv128, do128, rdy128);
  end

  task automatic send(input int inst, input logic [127:0] pt, input logic [127:0] key,
                      input logic knew, input bit gaps, input bit use_pat, input bit hold_dv);
    int w, n, cnt;
    bit seen;
    logic [127:0] mkey;
    logic [6:0] pat;
    pat = 7'b1001011;
    w = wid(inst);
    n = 128 / w;
    mkey = key;
`ifdef AES_KEY_REUSE_EN
    if (knew) kept_m[inst] = key;
    else mkey = kept_m[inst];
`endif
    for (int b = 0; b < n; b++) push(inst, word_of(aes_model(mkey, pt), b, w));
    set_rdy(inst, use_pat ? 1'b0 : 1'b1);
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          drive(inst, 1'b0, 128'h0, 128'h0, knew);
          @(posedge clk); #1;
        end
      end
      drive(inst, 1'b1, word_of(pt, b, w), word_of(key, b, w), knew);
      chk("in_ready_during_load", 128'(get_inr(inst)), 128'h1);
      @(posedge clk); #1;
    end
    if (hold_dv) drive(inst, 1'b1, ~pt, ~key, knew);
    else drive(inst, 1'b0, 128'h0, 128'h0, knew);
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 40) begin
      chk("in_ready_busy", 128'(get_inr(inst)), 128'h0);
      @(posedge clk); #1;
      cnt++;
      seen = get_dv(inst);
    end
    chk("latency_cycles", 128'(cnt), 128'd11);
    drive(inst, 1'b0, 128'h0, 128'h0, knew);
    if (use_pat) begin
      for (int p = 0; p < 7; p++) begin
        set_rdy(inst, pat[6-p]);
        chk("in_ready_output_phase", 128'(get_inr(inst)), 128'h0);
        @(posedge clk); #1;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        chk("in_ready_output_phase", 128'(get_inr(inst)), 128'h0);
        @(posedge clk); #1;
      end
    end
    chk("in_ready_after_block", 128'(get_inr(inst)), 128'h1);
    chk("core_dv_after_block", 128'(get_dv(inst)), 128'h0);
    chk("all_words_taken", 128'(q_size(inst)), 128'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 128'h0, 128'h0, 1'b0);
      set_rdy(i, 1'b0);
      kept_m[i] = 128'h0;
    end
    build_sbox();
    chk("model_sbox_00", 128'(sb_m[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb_m[8'h53]), 128'hed);
    chk("model_vector1", aes_model(K1, P1), C1);
    chk("model_vector2", aes_model(K2, P2), C2);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 128'(get_inr(i)), 128'h1);
      chk("reset_core_dv", 128'(get_dv(i)), 128'h0);
    end
    chk("reset_data_out", {do32, do8, do128[87:0]}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, P1, K1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1, P2, K2, 1'b1, 1'b1, 1'b0, 1'b0);
    send(0, P1, K1, 1'b1, 1'b0, 1'b1, 1'b0);
    send(0, P2, K2, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, word_of(P1, b, 32), word_of(K1, b, 32), 1'b1);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 128'h0, 128'h0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_reset", 128'(inr32), 128'h0);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_in_ready", 128'(inr32), 128'h1);
    chk("midrun_reset_core_dv", 128'(cdv32), 128'h0);
    chk("midrun_reset_data_out", 128'(do32), 128'h0);
    for (int i = 0; i < 3; i++) kept_m[i] = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", 128'(inr32), 128'h1);
    @(posedge clk); #1;
    send(0, P1, K1, 1'b1, 1'b0, 1'b0, 1'b0);

    send(0, P1, {128{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef AES_KEY_REUSE_EN
    chk("reuse_model_key", kept_m[0], K1);
`endif

    send(2, P2, K2, 1'b1, 1'b0, 1'b0, 1'b1);
    send(1, P1, K1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(q0.size() + q1.size() + q2.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
